mux2_rr_arbiter: RTL

//  Shares one DATA_W-wide 2:1 select path between two valid/ready requesters (A, B).
//  - Round-robin grant with burst lock on *_last_in.
//  - Drives sel_out to the select path; output goes to a 1-entry registered stage.
//  - Sits in front of any consumer that takes a single merged stream.

---
 rtl/mux2_arb_pkg.sv | 13 +
 rtl/mux2_bus.sv | 13 +
 rtl/mux2_rr_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mux2_arb_pkg.sv
// Shared state encoding and select constants for the two-requester round-robin arbiter.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2_bus.sv
// Combinational 2:1 select of a {last, data} bundle; the arbiter drives i_sel.
module mux2_bus #(
    parameter int W = 9
) (
    input  logic         i_sel,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter with burst lock between requesters A and B, feeding a
// single registered output stage through a shared 2:1 select path.
//
//  state   | meaning
//  IDLE    | no grant; arbitrating, no beat accepted this cycle
//  GRANT_A | A owns the path until last beat or MAX_BURST beats
//  GRANT_B | B owns the path until last beat or MAX_BURST beats
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              a_valid_in,
    input  logic [DATA_W-1:0] a_data_in,
    input  logic              a_last_in,
    output logic              a_ready_out,
    input  logic              b_valid_in,
    input  logic [DATA_W-1:0] b_data_in,
    input  logic              b_last_in,
    output logic              b_ready_out,
    output logic              y_valid_out,
    output logic [DATA_W-1:0] y_data_out,
    output logic              y_last_out,
    output logic              y_src_out,
    input  logic              y_ready_in,
    output logic              sel_out,
    output logic              busy_out
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t        r_state;
    logic              r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_y_valid;
    logic [DATA_W-1:0] r_y_data;
    logic              r_y_last;
    logic              r_y_src;

    logic              w_stage_free;
    logic              w_sel;
    logic              w_xfer;
    logic              w_cnt_term;
    logic [DATA_W:0]   w_bus;
    logic              w_bus_last;
    logic [DATA_W-1:0] w_bus_data;

    // Ready looks only at grant and stage occupancy, never at the valids.
    assign w_stage_free = !r_y_valid || y_ready_in;
    assign a_ready_out  = (r_state == GRANT_A) && w_stage_free;
    assign b_ready_out  = (r_state == GRANT_B) && w_stage_free;
    assign w_sel        = (r_state == GRANT_B) ? SEL_B : SEL_A;
    assign w_xfer       = (a_valid_in && a_ready_out) || (b_valid_in && b_ready_out);
    assign w_cnt_term   = (r_cnt == CNT_W'(MAX_BURST - 1));

    mux2_bus #(.W(DATA_W + 1)) u_bus (
        .i_sel (w_sel),
        .i_a   ({a_last_in, a_data_in}),
        .i_b   ({b_last_in, b_data_in}),
        .o_y   (w_bus)
    );

    assign w_bus_last = w_bus[DATA_W];
    assign w_bus_data = w_bus[DATA_W-1:0];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state   <= IDLE;
            r_ptr     <= SEL_B;
            r_cnt     <= '0;
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
            r_y_last  <= 1'b0;
            r_y_src   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (a_valid_in && b_valid_in)
                        r_state <= (r_ptr == SEL_B) ? GRANT_A : GRANT_B;
                    else if (a_valid_in)
                        r_state <= GRANT_A;
                    else if (b_valid_in)
                        r_state <= GRANT_B;
                end
                GRANT_A, GRANT_B: begin
                    if (w_xfer) begin
                        if (w_bus_last || w_cnt_term) begin
                            r_state <= IDLE;
                            r_ptr   <= w_sel;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A transfer into a draining stage replaces the beat without a bubble.
            if (w_xfer) begin
                r_y_valid <= 1'b1;
                r_y_data  <= w_bus_data;
                r_y_last  <= w_bus_last;
                r_y_src   <= w_sel;
            end else if (y_ready_in) begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign y_valid_out = r_y_valid;
    assign y_data_out  = r_y_data;
    assign y_last_out  = r_y_last;
    assign y_src_out   = r_y_src;
    assign sel_out     = w_sel;
    assign busy_out    = (r_state != IDLE);

endmodule
